// File: rtl/apb_master_bridge_if.sv
// Command, response and APB bus bundle for apb_master_bridge.
// The master modport is the bridge side; the slave modport is the environment side
// (command source, response sink and APB completer).
interface apb_master_bridge_if #(
   parameter int unsigned addr_width = 4,
   parameter int unsigned data_width = 128
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [addr_width-1:0] cmd_addr;
   logic [data_width-1:0] cmd_wdata;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [data_width-1:0] rsp_rdata;
   logic                  rsp_error;
   logic                  rsp_timeout;
   logic                  PSELx;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [addr_width-1:0] PADDR;
   logic [data_width-1:0] PWDATA;
   logic                  PREADY;
   logic                  PSLVERR;
   logic [data_width-1:0] PRDATA;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PSLVERR, PRDATA,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      output PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, PREADY, PSLVERR, PRDATA,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_error, rsp_timeout,
      input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
   );
endinterface

// File: rtl/apb_master_bridge.sv
// APB master bridge: runs one APB transfer (SETUP, ACCESS with wait states) per accepted
// command and returns read data / error status on a valid/ready response port.
// Every output is a register; nothing combinational reaches the outputs from the inputs.
// Optional macro APB_MASTER_TIMEOUT_EN: aborts ACCESS after timeout_cycles cycles of
// PREADY low and reports rsp_error=1, rsp_timeout=1. Without it the bridge waits forever.
module apb_master_bridge #(
   parameter int unsigned addr_width     = 4,
   parameter int unsigned data_width     = 128,
   parameter int unsigned timeout_cycles = 64
) (
   input logic                 PCLK,
   input logic                 PRESET,
   apb_master_bridge_if.master bus
);

   typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

   state_e                state_q;
   logic                  cmd_ready_q;
   logic                  rsp_valid_q;
   logic                  psel_q;
   logic                  penable_q;
   logic                  pwrite_q;
   logic [addr_width-1:0] paddr_q;
   logic [data_width-1:0] pwdata_q;
   logic [data_width-1:0] rdata_q;
   logic                  error_q;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(timeout_cycles + 1);
   // Last wait cycle index before abort, and the saturation ceiling.
   localparam logic [CntW-1:0] CntLast = CntW'(timeout_cycles - 1);
   localparam logic [CntW-1:0] CntMax  = CntW'(timeout_cycles);

   logic [CntW-1:0] cnt_q;
   logic            timeout_q;

   assign bus.rsp_timeout = timeout_q;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^timeout_cycles;
   assign bus.rsp_timeout    = 1'b0;
`endif

   // Transfer FSM with registered bus and response outputs.
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q     <= StIdle;
         cmd_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rdata_q     <= '0;
         error_q     <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
         cnt_q       <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               cmd_ready_q <= 1'b1;
               // cmd_ready_q is low on the first cycle out of reset, so no accept then.
               if (bus.cmd_valid && cmd_ready_q) begin
                  cmd_ready_q <= 1'b0;
                  psel_q      <= 1'b1;
                  pwrite_q    <= bus.cmd_write;
                  paddr_q     <= bus.cmd_addr;
                  pwdata_q    <= bus.cmd_wdata;
                  state_q     <= StSetup;
`ifdef APB_MASTER_TIMEOUT_EN
                  cnt_q       <= '0;
`endif
               end
            end
            StSetup: begin
               penable_q <= 1'b1;
               state_q   <= StAccess;
            end
            StAccess: begin
               // PREADY is checked first so a completion on the last allowed cycle wins.
               if (bus.PREADY) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rdata_q     <= pwrite_q ? '0 : bus.PRDATA;
                  error_q     <= bus.PSLVERR;
`ifdef APB_MASTER_TIMEOUT_EN
                  timeout_q   <= 1'b0;
`endif
                  state_q     <= StResp;
               end
`ifdef APB_MASTER_TIMEOUT_EN
               else if (cnt_q == CntLast) begin
                  psel_q      <= 1'b0;
                  penable_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rdata_q     <= '0;
                  error_q     <= 1'b1;
                  timeout_q   <= 1'b1;
                  state_q     <= StResp;
               end else if (cnt_q != CntMax) begin
                  cnt_q <= cnt_q + CntW'(1);
               end
`endif
            end
            StResp: begin
               if (bus.rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rdata_q;
   assign bus.rsp_error = error_q;
   assign bus.PSELx     = psel_q;
   assign bus.PENABLE   = penable_q;
   assign bus.PWRITE    = pwrite_q;
   assign bus.PADDR     = paddr_q;
   assign bus.PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus randomized transfers
// compared against a transaction-level model (latency, ACCESS length, response fields).
`timescale 1ns/1ps
module tb_apb_master_bridge;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 128;
`ifdef APB_MASTER_TIMEOUT_EN
   localparam int unsigned TO    = 8;
   localparam bit          TO_EN = 1'b1;
`else
   localparam int unsigned TO    = 64;
   localparam bit          TO_EN = 1'b0;
`endif
   localparam int Budget = 300;

   logic PCLK = 1'b0;
   logic PRESET;
   always #5 PCLK = ~PCLK;

   apb_master_bridge_if #(.addr_width(AW), .data_width(DW)) bus ();

   apb_master_bridge #(
      .addr_width    (AW),
      .data_width    (DW),
      .timeout_cycles(TO)
   ) dut (
      .PCLK  (PCLK),
      .PRESET(PRESET),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            wait_n;
      int            lat;
      int            setup_n;
      int            acc_n;
      bit            bus_ok;
      bit            got_rsp;
      logic [DW-1:0] rdata;
      logic          err;
      logic          to;
      bit            rsp_stable;
      bit            post_ok;
   } obs_t;

   typedef struct {
      int            lat;
      int            acc_n;
      logic [DW-1:0] rdata;
      logic          err;
      logic          to;
   } exp_t;

   // Transaction-level expectation: waits = ACCESS cycles with PREADY low before completion.
   function automatic exp_t model(input bit wr, input int waits, input bit err,
                                  input logic [DW-1:0] rd);
      exp_t e;
      if (TO_EN && waits >= int'(TO)) begin
         e.acc_n = int'(TO);
         e.lat   = 2 + int'(TO);
         e.rdata = '0;
         e.err   = 1'b1;
         e.to    = 1'b1;
      end else begin
         e.acc_n = waits + 1;
         e.lat   = 3 + waits;
         e.rdata = wr ? '0 : rd;
         e.err   = err;
         e.to    = 1'b0;
      end
      return e;
   endfunction

   function automatic logic [DW-1:0] rand_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Drives one command and plays the APB completer; called and returns on a falling edge.
   task automatic run_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int waits, input bit err, input logic [DW-1:0] rd,
                           input int hold, input bit keep_valid, output obs_t o);
      int n;
      o.wait_n = 0; o.lat = 0; o.setup_n = 0; o.acc_n = 0; o.bus_ok = 1'b1;
      o.got_rsp = 1'b0; o.rdata = '0; o.err = 1'b0; o.to = 1'b0;
      o.rsp_stable = 1'b1; o.post_ok = 1'b0;
      bus.cmd_valid = 1'b1;
      bus.cmd_write = wr;
      bus.cmd_addr  = a;
      bus.cmd_wdata = wd;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < Budget) begin
         @(negedge PCLK);
         n++;
      end
      o.wait_n = n;
      if (n >= Budget) begin
         bus.cmd_valid = 1'b0;
         return;
      end
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      o.lat = 1;
      while (bus.rsp_valid !== 1'b1 && o.lat < Budget) begin
         if (bus.PENABLE === 1'b1 && bus.PSELx !== 1'b1) o.bus_ok = 1'b0;
         if (bus.PSELx === 1'b1) begin
            if (bus.PADDR !== a || bus.PWDATA !== wd || bus.PWRITE !== wr) o.bus_ok = 1'b0;
            if (bus.PENABLE === 1'b1) begin
               if (o.setup_n == 0) o.bus_ok = 1'b0;
               if (o.acc_n == waits) begin
                  bus.PREADY = 1'b1; bus.PSLVERR = err; bus.PRDATA = rd;
               end else begin
                  bus.PREADY = 1'b0; bus.PSLVERR = 1'($urandom); bus.PRDATA = rand_data();
               end
               o.acc_n++;
            end else begin
               o.setup_n++;
               bus.PREADY = 1'($urandom); bus.PSLVERR = 1'($urandom); bus.PRDATA = rand_data();
            end
         end else begin
            bus.PREADY = 1'($urandom);
         end
         @(negedge PCLK);
         o.lat++;
      end
      bus.PREADY  = 1'b0;
      bus.PSLVERR = 1'b0;
      if (bus.rsp_valid !== 1'b1) return;
      o.got_rsp = 1'b1;
      o.rdata   = bus.rsp_rdata;
      o.err     = bus.rsp_error;
      o.to      = bus.rsp_timeout;
      if (keep_valid) bus.cmd_valid = 1'b1;
      for (int i = 0; i <= hold; i++) begin
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== o.rdata || bus.rsp_error !== o.err ||
             bus.rsp_timeout !== o.to || bus.cmd_ready !== 1'b0 || bus.PSELx !== 1'b0 ||
             bus.PENABLE !== 1'b0) o.rsp_stable = 1'b0;
         if (i == hold) bus.rsp_ready = 1'b1;
         else bus.PSLVERR = 1'($urandom);
         @(negedge PCLK);
      end
      bus.rsp_ready = 1'b0;
      bus.PSLVERR   = 1'b0;
      o.post_ok = (bus.rsp_valid === 1'b0 && bus.cmd_ready === 1'b1);
   endtask

   task automatic test_reset();
      PRESET = 1'b1;
      bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
      bus.rsp_ready = 1'b0; bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = '0;
      repeat (3) @(negedge PCLK);
      checks++;
      if ({bus.PSELx, bus.PENABLE, bus.PWRITE, bus.cmd_ready, bus.rsp_valid, bus.rsp_error,
           bus.rsp_timeout} !== 7'b0 || bus.PADDR !== '0 || bus.PWDATA !== '0 ||
          bus.rsp_rdata !== '0) begin
         errors++;
         $display("FAIL reset_outputs: psel=%b pen=%b crdy=%b rvld=%b paddr=%h required all 0",
                  bus.PSELx, bus.PENABLE, bus.cmd_ready, bus.rsp_valid, bus.PADDR);
      end
      PRESET = 1'b0;
      @(negedge PCLK);
      checks++;
      if (bus.cmd_ready !== 1'b1 || bus.PSELx !== 1'b0 || bus.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_release: cmd_ready=%b psel=%b rsp_valid=%b required 1 0 0",
                  bus.cmd_ready, bus.PSELx, bus.rsp_valid);
      end
   endtask

   task automatic test_write_zero_wait();
      obs_t o;
      exp_t e;
      logic [DW-1:0] wd = {16{8'hA5}};
      logic [DW-1:0] rd = rand_data();
      run_xfer(1'b1, 4'h3, wd, 0, 1'b0, rd, 0, 1'b0, o);
      e = model(1'b1, 0, 1'b0, rd);
      checks++;
      if (o.lat !== 3 || o.lat !== e.lat) begin
         errors++; $display("FAIL wr0_latency: got %0d required %0d", o.lat, e.lat);
      end
      checks++;
      if (o.setup_n !== 1 || o.acc_n !== e.acc_n || !o.bus_ok || !o.got_rsp) begin
         errors++;
         $display("FAIL wr0_bus: setup=%0d access=%0d bus_ok=%0d rsp=%0d required 1 %0d 1 1",
                  o.setup_n, o.acc_n, o.bus_ok, o.got_rsp, e.acc_n);
      end
      checks++;
      if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to}) begin
         errors++;
         $display("FAIL wr0_rsp: got rdata=%h err=%b to=%b required rdata=%h err=%b to=%b",
                  o.rdata, o.err, o.to, e.rdata, e.err, e.to);
      end
      checks++;
      if (!o.post_ok) begin
         errors++; $display("FAIL wr0_return_idle: got 0 required 1");
      end
   endtask

   task automatic test_read_wait16();
      obs_t o;
      exp_t e;
      logic [DW-1:0] rd = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
      run_xfer(1'b0, 4'h7, rand_data(), 16, 1'b0, rd, 1, 1'b0, o);
      e = model(1'b0, 16, 1'b0, rd);
      checks++;
      if (o.acc_n !== e.acc_n || o.lat !== e.lat) begin
         errors++;
         $display("FAIL rd16_timing: got access=%0d lat=%0d required access=%0d lat=%0d",
                  o.acc_n, o.lat, e.acc_n, e.lat);
      end
      checks++;
      if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to}) begin
         errors++;
         $display("FAIL rd16_rsp: got rdata=%h err=%b to=%b required rdata=%h err=%b to=%b",
                  o.rdata, o.err, o.to, e.rdata, e.err, e.to);
      end
      checks++;
      if (!o.bus_ok || o.setup_n !== 1 || !o.rsp_stable) begin
         errors++;
         $display("FAIL rd16_bus: bus_ok=%0d setup=%0d stable=%0d required 1 1 1",
                  o.bus_ok, o.setup_n, o.rsp_stable);
      end
   endtask

   task automatic test_slave_error();
      obs_t o;
      exp_t e;
      logic [DW-1:0] rd = rand_data();
      run_xfer(1'b0, 4'hC, rand_data(), 2, 1'b1, rd, 0, 1'b0, o);
      e = model(1'b0, 2, 1'b1, rd);
      checks++;
      if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to} || !o.got_rsp) begin
         errors++;
         $display("FAIL slverr_rsp: got err=%b to=%b rdata=%h required err=%b to=%b rdata=%h",
                  o.err, o.to, o.rdata, e.err, e.to, e.rdata);
      end
      rd = rand_data();
      run_xfer(1'b0, 4'hD, rand_data(), 0, 1'b0, rd, 0, 1'b0, o);
      checks++;
      if (o.wait_n !== 0 || o.err !== 1'b0 || o.rdata !== rd) begin
         errors++;
         $display("FAIL slverr_next: got wait=%0d err=%b rdata=%h required 0 0 %h",
                  o.wait_n, o.err, o.rdata, rd);
      end
   endtask

   task automatic test_backpressure();
      obs_t o;
      logic [DW-1:0] wd = rand_data();
      run_xfer(1'b1, 4'h9, wd, 1, 1'b0, rand_data(), 5, 1'b1, o);
      checks++;
      if (!o.rsp_stable || !o.post_ok) begin
         errors++;
         $display("FAIL bp_hold: stable=%0d post=%0d required 1 1", o.rsp_stable, o.post_ok);
      end
      run_xfer(1'b1, 4'h9, wd, 0, 1'b0, rand_data(), 0, 1'b0, o);
      checks++;
      if (o.wait_n !== 0 || o.lat !== 3) begin
         errors++;
         $display("FAIL bp_accept: got wait=%0d lat=%0d required 0 3", o.wait_n, o.lat);
      end
   endtask

   task automatic test_back_to_back();
      obs_t o;
      for (int i = 0; i < 3; i++) begin
         run_xfer(1'($urandom), 4'($urandom), rand_data(), 0, 1'b0, rand_data(), 0, 1'b0, o);
         checks++;
         if (o.wait_n !== 0 || o.lat !== 3 || !o.post_ok) begin
            errors++;
            $display("FAIL b2b_%0d: got wait=%0d lat=%0d post=%0d required 0 3 1",
                     i, o.wait_n, o.lat, o.post_ok);
         end
      end
   endtask

`ifdef APB_MASTER_TIMEOUT_EN
   task automatic test_timeout();
      obs_t o;
      exp_t e;
      run_xfer(1'b0, 4'h6, rand_data(), 1000, 1'b0, rand_data(), 0, 1'b0, o);
      e = model(1'b0, 1000, 1'b0, '0);
      checks++;
      if (o.acc_n !== 8 || o.lat !== e.lat) begin
         errors++;
         $display("FAIL timeout_len: got access=%0d lat=%0d required 8 %0d", o.acc_n, o.lat, e.lat);
      end
      checks++;
      if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to}) begin
         errors++;
         $display("FAIL timeout_rsp: got err=%b to=%b rdata=%h required 1 1 0",
                  o.err, o.to, o.rdata);
      end
   endtask
`endif

   task automatic test_random();
      obs_t          o;
      exp_t          e;
      bit            wr, err;
      int            waits;
      logic [DW-1:0] rd, wd;
      logic [AW-1:0] a;
      for (int i = 0; i < 40; i++) begin
         wr    = 1'($urandom);
         err   = 1'($urandom);
         waits = int'($urandom_range(0, 10));
         a     = AW'($urandom);
         wd    = rand_data();
         rd    = rand_data();
         run_xfer(wr, a, wd, waits, err, rd, int'($urandom_range(0, 3)), 1'b0, o);
         e = model(wr, waits, err, rd);
         checks++;
         if (o.lat !== e.lat || o.acc_n !== e.acc_n) begin
            errors++;
            $display("FAIL rand_%0d_timing: got lat=%0d access=%0d required lat=%0d access=%0d",
                     i, o.lat, o.acc_n, e.lat, e.acc_n);
         end
         checks++;
         if ({o.rdata, o.err, o.to} !== {e.rdata, e.err, e.to}) begin
            errors++;
            $display("FAIL rand_%0d_rsp: got %h/%b/%b required %h/%b/%b",
                     i, o.rdata, o.err, o.to, e.rdata, e.err, e.to);
         end
         checks++;
         if (!o.bus_ok || o.setup_n !== 1 || !o.rsp_stable || !o.post_ok) begin
            errors++;
            $display("FAIL rand_%0d_proto: bus=%0d setup=%0d stable=%0d post=%0d required 1 1 1 1",
                     i, o.bus_ok, o.setup_n, o.rsp_stable, o.post_ok);
         end
      end
   endtask

   task automatic test_reset_mid_access();
      int n = 0;
      bit clean = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'h5; bus.cmd_wdata = rand_data();
      bus.PREADY = 1'b0;
      while (bus.cmd_ready !== 1'b1 && n < Budget) begin
         @(negedge PCLK);
         n++;
      end
      @(negedge PCLK);
      bus.cmd_valid = 1'b0;
      repeat (2) @(negedge PCLK);
      checks++;
      if (bus.PSELx !== 1'b1 || bus.PENABLE !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_in_access: psel=%b pen=%b required 1 1", bus.PSELx, bus.PENABLE);
      end
      #2 PRESET = 1'b1;
      #1;
      checks++;
      if ({bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready} !== 4'b0 || bus.PADDR !== '0) begin
         errors++;
         $display("FAIL rstmid_async: psel=%b pen=%b rvld=%b crdy=%b paddr=%h required all 0",
                  bus.PSELx, bus.PENABLE, bus.rsp_valid, bus.cmd_ready, bus.PADDR);
      end
      @(negedge PCLK);
      PRESET = 1'b0;
      bus.PREADY = 1'b1; bus.PRDATA = rand_data();
      repeat (4) begin
         @(negedge PCLK);
         if (bus.rsp_valid !== 1'b0 || bus.PSELx !== 1'b0) clean = 1'b0;
      end
      checks++;
      if (!clean || bus.cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_after: clean=%0d cmd_ready=%b required 1 1", clean, bus.cmd_ready);
      end
      bus.PREADY = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_wait16();
      test_slave_error();
      test_backpressure();
      test_back_to_back();
`ifdef APB_MASTER_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      test_reset_mid_access();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
